// File: rtl/jaxa_activity_monitor.sv
// SpaceWire receive-activity supervisor: input synchronizer, saturating edge counter,
// idle-timeout FSM and a 4-word register slave. Optional interrupt via JAXA_ACTIVITY_IRQ_EN.
module jaxa_activity_monitor #(
    parameter int unsigned TIMEOUT_DEFAULT = 1000,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    input  logic        in_port,
    output logic [31:0] readdata,
    output logic        link_active,
    output logic        irq
);
    localparam int unsigned TH_W = 24;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_TIMEOUT  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [TH_W-1:0]        idle_cnt_q, idle_cnt_d, idle_inc, threshold_q;
    logic                   timeout_set, timeout_flag_q, enable_q, irq_en;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   act_s, act_d, rise;
    logic [CNT_WIDTH-1:0]   edge_cnt_q;
    logic                   wr_status, wr_thresh, wr_edge, wr_ctrl;
    logic [31:0]            rd_mux;
    logic                   unused_wdata;

    assign act_s     = sync_q[SYNC_STAGES-1];
    assign rise      = act_s & ~act_d;
    assign wr_status = write && (address == 2'd0);
    assign wr_thresh = write && (address == 2'd1);
    assign wr_edge   = write && (address == 2'd2);
    assign wr_ctrl   = write && (address == 2'd3);
    assign unused_wdata = ^writedata[31:24];

    // Metastability chain plus one delay flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            act_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            act_d  <= act_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_DISABLED;
            idle_cnt_q  <= '0;
            link_active <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            link_active <= (state_d == ST_ACTIVE);
        end
    end

    // Saturating increment keeps idle_cnt bounded when threshold is 0 or lowered below it
    assign idle_inc = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + TH_W'(1);

    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        timeout_set = 1'b0;
        if (!enable_q) begin
            state_d    = ST_DISABLED;
            idle_cnt_d = '0;
        end else begin
            case (state_q)
                ST_DISABLED: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (act_s) begin
                        state_d    = ST_ACTIVE;
                        idle_cnt_d = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (act_s) begin
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_inc;
                        if ((threshold_q != '0) && (idle_inc == threshold_q)) begin
                            state_d     = ST_TIMEOUT;
                            timeout_set = 1'b1;
                        end
                    end
                end
                ST_TIMEOUT: begin
                    if (act_s) begin
                        state_d    = ST_ACTIVE;
                        idle_cnt_d = '0;
                    end
                end
                default: state_d = ST_DISABLED;
            endcase
        end
    end

    // Register file, edge counter and timeout flag (a set beats a software clear)
    always_ff @(posedge clk) begin
        if (reset) begin
            threshold_q    <= TH_W'(TIMEOUT_DEFAULT);
            enable_q       <= 1'b0;
            timeout_flag_q <= 1'b0;
            edge_cnt_q     <= '0;
        end else begin
            if (wr_thresh) threshold_q <= writedata[TH_W-1:0];
            if (wr_ctrl)   enable_q    <= writedata[0];
            if (timeout_set)
                timeout_flag_q <= 1'b1;
            else if (wr_status && writedata[2])
                timeout_flag_q <= 1'b0;
            if (rise && enable_q) begin
                if (wr_edge)
                    edge_cnt_q <= CNT_WIDTH'(1);
                else if (edge_cnt_q != '1)
                    edge_cnt_q <= edge_cnt_q + CNT_WIDTH'(1);
            end else if (wr_edge) begin
                edge_cnt_q <= '0;
            end
        end
    end

`ifdef JAXA_ACTIVITY_IRQ_EN
    logic irq_en_q;
    assign irq_en = irq_en_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en_q <= writedata[1];
            irq <= timeout_flag_q & irq_en_q;
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux = {26'd0, state_q, 1'b0, timeout_flag_q, link_active, act_s};
            2'd1: rd_mux = {8'd0, threshold_q};
            2'd2: rd_mux = 32'(edge_cnt_q);
            2'd3: rd_mux = {30'd0, irq_en, enable_q};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else if (read)
            readdata <= rd_mux;
    end
endmodule

// File: tb/tb_jaxa_activity_monitor.sv
// Directed self-checking bench for jaxa_activity_monitor; follows JAXA_ACTIVITY_IRQ_EN for irq expectations.
module tb_jaxa_activity_monitor;
    localparam int unsigned SYNC = 2;
    // Narrower counter keeps the saturation run short
    localparam int unsigned CW   = 12;
`ifdef JAXA_ACTIVITY_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, write, read, in_port;
    logic [1:0]  address;
    logic [31:0] writedata, readdata;
    logic        link_active, irq;
    int          n_pass = 0, n_total = 0, n_fail = 0;

    jaxa_activity_monitor #(
        .TIMEOUT_DEFAULT(1000), .CNT_WIDTH(CW), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .read(read), .in_port(in_port),
        .readdata(readdata), .link_active(link_active), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        @(negedge clk); address = a; read = 1'b1;
        @(negedge clk); read = 1'b0; d = readdata;
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk); address = a; writedata = d; write = 1'b1;
        @(negedge clk); write = 1'b0;
    endtask

    task automatic pulse();
        @(negedge clk); in_port = 1'b1;
        @(negedge clk); in_port = 1'b0;
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; read = 1'b0; in_port = 1'b0;
        address = '0; writedata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_readdata", readdata, 32'h0);
        check("rst_link", 32'(link_active), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rd_check(2'd0, 32'h0, "rst_status");
        rd_check(2'd1, 32'h3E8, "rst_threshold");
        @(negedge clk);
        check("read_hold", readdata, 32'h3E8);
        rd_check(2'd2, 32'h0, "rst_edge");
        rd_check(2'd3, 32'h0, "rst_control");

        // Enable and first activity pulse
        wr(2'd3, 32'h1);
        pulse();
        for (int i = 0; i < int'(SYNC) + 2 && link_active !== 1'b1; i++) @(negedge clk);
        check("first_active_link", 32'(link_active), 32'h1);
        rd_check(2'd0, 32'h22, "first_active_status");
        rd_check(2'd2, 32'h1, "first_edge");

        // Threshold 10: let it time out, clear flag, then time a precise idle run
        wr(2'd1, 32'd10);
        repeat (20) @(negedge clk);
        wr(2'd0, 32'h4);
        rd_check(2'd0, 32'h30, "timeout_cleared");
        pulse();
        repeat (2) @(negedge clk);
        check("reactivate_link", 32'(link_active), 32'h1);
        repeat (9) @(negedge clk);
        check("idle9_link", 32'(link_active), 32'h1);
        @(negedge clk);
        check("idle10_link", 32'(link_active), 32'h0);
        rd_check(2'd0, 32'h34, "timeout_status");
        pulse();
        repeat (2) @(negedge clk);
        rd_check(2'd0, 32'h26, "active_flag_sticky");
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h4);
        rd_check(2'd0, 32'h22, "flag_clear_active");
        rd_check(2'd2, 32'h3, "edge_three");

        // Saturation, then write-vs-rise collision
        wr(2'd2, 32'h0);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk); in_port = 1'b1;
            @(negedge clk); in_port = 1'b0;
        end
        repeat (4) @(negedge clk);
        rd_check(2'd2, 32'hFFF, "edge_saturate");
        @(negedge clk); in_port = 1'b1;
        @(negedge clk); in_port = 1'b0;
        @(negedge clk); address = 2'd2; writedata = 32'h0; write = 1'b1;
        @(negedge clk); write = 1'b0;
        rd_check(2'd2, 32'h1, "edge_write_rise");
        wr(2'd2, 32'h0);
        rd_check(2'd2, 32'h0, "edge_write_clear");

        // Threshold 0 never times out; then disable mid-ACTIVE
        repeat (5000) @(negedge clk);
        check("thr0_link", 32'(link_active), 32'h1);
        rd_check(2'd0, 32'h22, "thr0_status");
        wr(2'd3, 32'h0);
        check("disable_same_cycle", 32'(link_active), 32'h1);
        @(negedge clk);
        check("disable_next_cycle", 32'(link_active), 32'h0);
        rd_check(2'd0, 32'h0, "disabled_status");
        rd_check(2'd3, 32'h0, "disabled_control");

        // Interrupt path
        wr(2'd1, 32'd10);
        wr(2'd3, 32'h3);
        rd_check(2'd3, IRQ_ON ? 32'h3 : 32'h1, "control_irq_en");
        pulse();
        repeat (12) @(negedge clk);
        check("timeout_link", 32'(link_active), 32'h0);
        check("irq_pre", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_rise", 32'(irq), 32'(IRQ_ON));
        wr(2'd0, 32'h4);
        check("irq_hold", 32'(irq), 32'(IRQ_ON));
        @(negedge clk);
        check("irq_fall", 32'(irq), 32'h0);

        // Reset while ACTIVE
        pulse();
        repeat (2) @(negedge clk);
        check("pre_reset_link", 32'(link_active), 32'h1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("mid_rst_readdata", readdata, 32'h0);
        check("mid_rst_link", 32'(link_active), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        rd_check(2'd0, 32'h0, "mid_rst_status");
        rd_check(2'd1, 32'h3E8, "mid_rst_threshold");
        rd_check(2'd2, 32'h0, "mid_rst_edge");
        rd_check(2'd3, 32'h0, "mid_rst_control");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
